// File: rtl/trace_capture.sv
// trace_capture: edge-triggered event capture into a first-word-fall-through
// FIFO. Each entry holds tag, (optionally clamped) value, sign flag and the
// free-running cycle timestamp taken when the event was seen. A halt edge
// records a last entry, then the block drains and parks in DONE until reset.
module trace_capture #(
  parameter int DATA_W    = 24,
  parameter int DEPTH     = 16,
  parameter int TS_W      = 20,
  parameter int NEG_CLAMP = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     notify,
  input  logic                     halt,
  input  logic [DATA_W-1:0]        tag_in,
  input  logic [DATA_W-1:0]        val_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_tag,
  output logic [DATA_W-1:0]        out_val,
  output logic                     out_neg,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        r_state;
  logic              r_notify_q;
  logic              r_halt_q;
  logic [TS_W-1:0]   r_ts;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow;

  logic [DATA_W-1:0] r_mem_tag [DEPTH];
  logic [DATA_W-1:0] r_mem_val [DEPTH];
  logic              r_mem_neg [DEPTH];
  logic [TS_W-1:0]   r_mem_ts  [DEPTH];

  logic              w_notify_edge;
  logic              w_halt_edge;
  logic              w_capture;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [DATA_W-1:0] w_val_store;

  assign w_notify_edge = notify & ~r_notify_q;
  assign w_halt_edge   = halt & ~r_halt_q;
  // Coincident notify and halt edges still yield a single entry.
  assign w_capture     = (r_state == ST_RUN) && (w_notify_edge || w_halt_edge);
  assign w_full        = (r_count == (AW+1)'(DEPTH));
  assign w_empty       = (r_count == '0);
  assign w_pop         = !w_empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push        = w_capture && (!w_full || w_pop);
  assign w_drop        = w_capture && w_full && !w_pop;
  assign w_val_store   = ((NEG_CLAMP != 0) && val_in[DATA_W-1]) ? '0 : val_in;

  // Edge-detect copies of the level inputs; cleared by reset so that an input
  // held high through reset is seen as an edge right afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_notify_q <= 1'b0;
      r_halt_q   <= 1'b0;
    end else begin
      r_notify_q <= notify;
      r_halt_q   <= halt;
    end
  end

  // Saturating free-running cycle timestamp.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts <= '0;
    end else if (r_ts != '1) begin
      r_ts <= r_ts + 1'b1;
    end
  end

  // Capture/drain sequencing; DONE is only left through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:   if (w_halt_edge) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_empty) r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_DONE;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Per-entry storage; the head is read combinationally for fall-through.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Load this slot when it is the write target of an accepted push.
      always_ff @(posedge clk) begin
        if (!rst && w_push && (r_wr_ptr == AW'(gi))) begin
          r_mem_tag[gi] <= tag_in;
          r_mem_val[gi] <= w_val_store;
          r_mem_neg[gi] <= val_in[DATA_W-1];
          r_mem_ts[gi]  <= r_ts;
        end
      end
    end
  endgenerate

  assign out_valid = !w_empty;
  assign out_tag   = r_mem_tag[r_rd_ptr];
  assign out_val   = r_mem_val[r_rd_ptr];
  assign out_neg   = r_mem_neg[r_rd_ptr];
  assign out_ts    = r_mem_ts[r_rd_ptr];
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign done      = (r_state == ST_DONE);

endmodule
